// File: rtl/apb_pkg.sv
// Shared types for the APB4 requester: FSM state encoding, command record, default PPROT.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_e;

  typedef struct packed {
    logic                    write;
    logic [APB_ADDR_W-1:0]   addr;
    logic [APB_DATA_W-1:0]   wdata;
    logic [APB_DATA_W/8-1:0] strb;
    logic [2:0]              prot;
  } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// PREADY wait-state counter: cleared before ACCESS, counts low-PREADY cycles, flags the abort cycle.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturates at LAST so a disabled timeout (TIMEOUT_CYC=0) never wraps.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (TIMEOUT_CYC != 0) && en && (count_q == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: turns one accepted command into a SETUP/ACCESS transfer and returns a response.
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  // Both streams transfer on a cycle where valid & ready are high at the PCLK edge; the
  // producer holds valid and payload stable until then, ready may change freely.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [2:0]          PPROT,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR,
  output apb_req_state_e      dbg_state
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [2:0]        prot;
  } cmd_t;

  localparam cmd_t CMD_RST = '{
    write: 1'b0,
    addr:  '0,
    wdata: '0,
    strb:  '0,
    prot:  APB_PROT_DEFAULT
  };

  apb_req_state_e    state_q,       state_d;
  cmd_t              cmd_q,         cmd_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic              rsp_err_q,     rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_expire;

  apb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expire  (cnt_expire)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_clr       = (state_q == SETUP);
    cnt_en        = (state_q == ACCESS) && !PREADY;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // Reads carry zero data and strobes so PWDATA/PSTRB are already clean in SETUP.
          cmd_d.write = cmd_write;
          cmd_d.addr  = cmd_addr;
          cmd_d.wdata = cmd_write ? cmd_wdata : '0;
          cmd_d.strb  = cmd_write ? cmd_strb : '0;
          cmd_d.prot  = cmd_prot;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = cmd_q.write ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (cnt_expire) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cmd_q         <= CMD_RST;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Address/control stay parked on the last command between transfers.
  assign PADDR   = cmd_q.addr;
  assign PPROT   = cmd_q.prot;
  assign PWRITE  = cmd_q.write;
  assign PWDATA  = cmd_q.wdata;
  assign PSTRB   = cmd_q.strb;
  assign PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE = (state_q == ACCESS);

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: behavioural completer, reference memory/FIFO model, response scoreboard.
module tb_apb_requester;
  import apb_pkg::*;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam logic [31:0] FIFO_ADDR = 32'h0000_0000;
  localparam logic [31:0] ERR_ADDR  = 32'h0000_0040;

  // ---------------- clock / reset ----------------
  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr  = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [STRB_W-1:0] cmd_strb  = '0;
  logic [2:0]        cmd_prot  = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] PADDR;
  logic [2:0]        PPROT;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic              PREADY  = 1'b0;
  logic [DATA_W-1:0] PRDATA  = '0;
  logic              PSLVERR = 1'b0;
  apb_req_state_e    dbg_state;

  apb_requester #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .PCLK (PCLK), .PRESETn (PRESETn),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_strb (cmd_strb), .cmd_prot (cmd_prot),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_err (rsp_err), .rsp_timeout (rsp_timeout),
    .PADDR (PADDR), .PPROT (PPROT), .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE),
    .PWDATA (PWDATA), .PSTRB (PSTRB), .PREADY (PREADY), .PRDATA (PRDATA), .PSLVERR (PSLVERR),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [DATA_W+1:0] exp_q[$];     // {timeout, err, rdata}
  int                lat_q[$];     // accept -> first rsp_valid, in cycles
  apb_cmd_t          apb_exp_q[$]; // what SETUP must present
  int                wait_q[$];    // PREADY-low cycles the completer inserts
  int                hold_q[$];    // cycles rsp_ready stays low

  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] ref_fifo[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing required=present t=%0t", name, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int wt, input int hold);
    apb_cmd_t    c;
    logic [31:0] rd;
    logic        to;
    logic        err;
    logic        accepted;
    to  = (wt >= TIMEOUT_CYC);
    err = to || (addr == ERR_ADDR);
    rd  = '0;
    if (!err) begin
      if (wr) begin
        if (addr == FIFO_ADDR) ref_fifo.push_back(merge(32'h0, wdata, strb));
        else ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0, wdata, strb);
      end else begin
        if (addr == FIFO_ADDR) rd = (ref_fifo.size() > 0) ? ref_fifo.pop_front() : 32'h0;
        else rd = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
      end
    end
    c.write = wr;
    c.addr  = addr;
    c.wdata = wr ? wdata : 32'h0;
    c.strb  = wr ? strb : 4'h0;
    c.prot  = prot;
    apb_exp_q.push_back(c);
    exp_q.push_back({to, err, rd});
    lat_q.push_back(2 + (to ? TIMEOUT_CYC : wt + 1));
    wait_q.push_back(wt);
    hold_q.push_back(hold);

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    accepted  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge PCLK);
      if (cmd_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom_range(0, 15));
    cmd_prot  = 3'($urandom_range(0, 7));
    if (!accepted) fail("cmd_accept_timeout");
  endtask

  // ---------------- behavioural completer ----------------
  int          wait_left = -1;
  logic [31:0] comp_mem [bit [31:0]];
  logic [31:0] comp_fifo[$];

  always @(posedge PCLK) begin
    #1;
    if (!PRESETn) begin
      PREADY    = 1'b0;
      wait_left = -1;
    end else if (PSEL && !PENABLE) begin
      wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      PREADY    = 1'b0;
      PRDATA    = $urandom;
      PSLVERR   = 1'($urandom_range(0, 1));
    end else if (PSEL && PENABLE && wait_left == 0) begin
      PREADY    = 1'b1;
      wait_left = -1;
      if (PADDR == ERR_ADDR) begin
        PSLVERR = 1'b1;
        PRDATA  = 32'h0;
      end else begin
        PSLVERR = 1'b0;
        PRDATA  = $urandom;
        if (PWRITE) begin
          if (PADDR == FIFO_ADDR) comp_fifo.push_back(merge(32'h0, PWDATA, PSTRB));
          else comp_mem[PADDR] = merge(comp_mem.exists(PADDR) ? comp_mem[PADDR] : 32'h0, PWDATA, PSTRB);
        end else if (PADDR == FIFO_ADDR) begin
          PRDATA = (comp_fifo.size() > 0) ? comp_fifo.pop_front() : 32'h0;
        end else begin
          PRDATA = comp_mem.exists(PADDR) ? comp_mem[PADDR] : 32'h0;
        end
      end
    end else begin
      if (PSEL && PENABLE) wait_left--;
      PREADY  = (PSEL && PENABLE) ? 1'b0 : 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- response sink ----------------
  int hold_left = -1;

  always @(posedge PCLK) begin
    #1;
    if (!PRESETn || !rsp_valid) begin
      hold_left = -1;
      rsp_ready = 1'($urandom_range(0, 1));
    end else begin
      if (hold_left < 0) hold_left = (hold_q.size() > 0) ? hold_q.pop_front() : 0;
      if (hold_left == 0) begin
        rsp_ready = 1'b1;
      end else begin
        rsp_ready = 1'b0;
        hold_left--;
      end
    end
  end

  // ---------------- monitor ----------------
  int                cyc = 0;
  int                acc_cyc = 0;
  logic              prev_psel = 1'b0;
  logic              prev_pend = 1'b0;
  logic [DATA_W+1:0] held_rsp = '0;
  apb_cmd_t          setup_snap;
  apb_cmd_t          cur;

  always @(negedge PCLK) begin
    cyc++;
    if (!PRESETn) begin
      prev_psel = 1'b0;
      prev_pend = 1'b0;
    end else begin
      cur = '{write: PWRITE, addr: PADDR, wdata: PWDATA, strb: PSTRB, prot: PPROT};
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      check("penable_without_psel", PENABLE && !PSEL, 1'b0);
      if (PSEL && !PENABLE) begin
        check("psel_gap", prev_psel, 1'b0);
        setup_snap = cur;
        if (apb_exp_q.size() == 0) begin
          fail("apb_expected_cmd");
        end else begin
          apb_cmd_t e;
          e = apb_exp_q.pop_front();
          check("setup_paddr", cur.addr, e.addr);
          check("setup_pwrite", cur.write, e.write);
          check("setup_pwdata", cur.wdata, e.wdata);
          check("setup_pstrb", cur.strb, e.strb);
          check("setup_pprot", cur.prot, e.prot);
        end
      end
      if (PSEL && PENABLE) begin
        check("access_after_setup", prev_psel, 1'b1);
        check("access_stable", cur, setup_snap);
      end
      if (PSEL || rsp_valid) check("cmd_ready_busy", cmd_ready, 1'b0);
      if (rsp_valid) begin
        if (!prev_pend) begin
          check("rsp_psel_low", PSEL, 1'b0);
          if (lat_q.size() == 0) fail("rsp_expected_latency");
          else check("rsp_latency", cyc - acc_cyc, lat_q.pop_front());
        end else begin
          check("rsp_stable", {rsp_timeout, rsp_err, rsp_rdata}, held_rsp);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            fail("rsp_expected_entry");
          end else begin
            logic [DATA_W+1:0] e;
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e[DATA_W-1:0]);
            check("rsp_err", rsp_err, e[DATA_W]);
            check("rsp_timeout", rsp_timeout, e[DATA_W+1]);
          end
        end else begin
          held_rsp = {rsp_timeout, rsp_err, rsp_rdata};
        end
      end
      prev_psel = PSEL;
      prev_pend = rsp_valid && !rsp_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic reset_mid_access();
    logic seen;
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'b000, 100, 0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        seen = 1'b1;
        break;
      end
    end
    check("reset_reach_access", seen, 1'b1);
    @(posedge PCLK);
    #3;
    PRESETn = 1'b0;
    #1;
    check("reset_psel", PSEL, 1'b0);
    check("reset_penable", PENABLE, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_state", dbg_state, IDLE);
    exp_q.delete();
    lat_q.delete();
    apb_exp_q.delete();
    wait_q.delete();
    hold_q.delete();
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
  endtask

  initial begin
    logic [31:0] addrs[5];
    logic [31:0] a;
    int          r;
    int          wt;
    logic        drained;
    addrs = '{32'h0000_0000, 32'h0000_0040, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008};

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_psel", PSEL, 1'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pstrb", PSTRB, 4'h0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_pprot", PPROT, 3'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_bits", {rsp_timeout, rsp_err, rsp_rdata}, 34'h0);
    check("rst_state", dbg_state, IDLE);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    // directed: FIFO write/read, register write/read, error slot, waits, timeout edges, backpressure
    issue(1'b1, 32'h0000_0000, 32'h0000_0004, 4'hF, 3'b000, 0, 0);
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'b000, 0, 0);
    issue(1'b1, 32'h8000_0000, 32'h0000_00A5, 4'hF, 3'b010, 0, 0);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, 0);
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000, 0, 0);
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'b000, 3, 0);
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'b000, 100, 0);
    issue(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 15, 0);
    issue(1'b1, 32'h8000_0004, 32'h1111_1111, 4'hF, 3'b000, 16, 0);
    issue(1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0101, 3'b101, 0, 5);
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0, 3'b000, 1, 5);

    for (int i = 0; i < 60; i++) begin
      a = addrs[$urandom_range(0, 4)];
      r = $urandom_range(0, 19);
      if (r < 14) wt = $urandom_range(0, 3);
      else if (r < 16) wt = 15;
      else if (r < 18) wt = 16;
      else wt = $urandom_range(17, 20);
      issue(1'($urandom_range(0, 1)), a, $urandom,
            (a == FIFO_ADDR) ? 4'hF : 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), wt, $urandom_range(0, 3));
    end

    reset_mid_access();
    @(posedge PCLK);
    #1;
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'b000, 0, 0);
    issue(1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'b1100, 3'b111, 2, 1);
    issue(1'b0, 32'h8000_0008, 32'h0, 4'h0, 3'b000, 0, 0);

    drained = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge PCLK);
      if (exp_q.size() == 0 && dbg_state == IDLE) begin
        drained = 1'b1;
        break;
      end
    end
    check("drain_done", drained, 1'b1);
    check("drain_latency_queue", lat_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
